fetch_queue: RTL and testbench

Instruction fetch stage upstream of decode (ImmGen, ControlUnit, RegFile read). Holds the fetch PC, issues word requests to the instruction memory over a req/ack handshake with one request outstanding, and buffers returned words with their PCs in a DEPTH-entry FIFO. Decode consumes entries over a valid/ready interface. A branch redirect flushes the queue, squashes any in-flight fetch and restarts fetching at the target.

---
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fetch_queue.sv | 173 +++++++++++++++++
 tb/tb_fetch_queue.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Bundles the instruction-memory handshake, the redirect request and the
// decode-side valid/ready channel of the fetch queue.
interface fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;

  // Fetch-queue side: issues requests and presents queued instructions.
  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );

  // Environment side: instruction memory, branch unit and decode.
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: one outstanding word request to instruction memory,
// returned words buffered with their PCs in a DEPTH-entry FIFO for decode.
// A redirect flushes the FIFO and squashes any request still in flight.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t             state_r;
  logic [31:0]        fetch_pc_r;
  logic               imem_req_r;
  logic [31:0]        imem_addr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [31:0]        pc_mem_r   [DEPTH];
  logic [31:0]        inst_mem_r [DEPTH];

  logic               ack_s;
  logic               push_s;
  logic               pop_s;
  logic               room_s;
  logic               valid_s;
  logic [CNT_W-1:0]   count_next_s;
  logic [31:0]        target_s;
  logic [31:0]        redirect_lsb_unused_s;

  assign redirect_lsb_unused_s = bus.redirect_pc;

  // Handshake qualification and next-cycle occupancy (flush wins over push/pop).
  always_comb begin
    valid_s  = (count_r != {CNT_W{1'b0}});
    // imem_req is high in both FETCH and DROP, so any ack there is real.
    ack_s    = (state_r != IDLE) && bus.imem_ack;
    push_s   = (state_r == FETCH) && bus.imem_ack && !bus.redirect;
    pop_s    = valid_s && bus.inst_ready;
    target_s = {bus.redirect_pc[31:2], 2'b00};
    if (bus.redirect) begin
      count_next_s = {CNT_W{1'b0}};
    end else begin
      count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
    // Only request when the word can be stored, so an ack never meets a full queue.
    room_s = (count_next_s < CNT_W'(DEPTH));
  end

  // Fetch control FSM with registered request/address outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      fetch_pc_r  <= RESET_PC;
      imem_req_r  <= 1'b0;
      imem_addr_r <= RESET_PC;
    end else if (bus.redirect) begin
      fetch_pc_r <= target_s;
      case (state_r)
        FETCH, DROP: begin
          imem_req_r <= 1'b1;
          if (ack_s) begin
            state_r     <= FETCH;
            imem_addr_r <= target_s;
          end else begin
            // Request still in flight: hold its address and discard its data later.
            state_r <= DROP;
          end
        end
        IDLE: begin
          state_r     <= FETCH;
          imem_req_r  <= 1'b1;
          imem_addr_r <= target_s;
        end
        default: begin
          state_r    <= IDLE;
          imem_req_r <= 1'b0;
        end
      endcase
    end else begin
      case (state_r)
        IDLE: begin
          if (room_s) begin
            state_r     <= FETCH;
            imem_req_r  <= 1'b1;
            imem_addr_r <= fetch_pc_r;
          end
        end
        FETCH: begin
          if (ack_s) begin
            fetch_pc_r <= fetch_pc_r + 32'd4;
            if (room_s) begin
              imem_req_r  <= 1'b1;
              imem_addr_r <= fetch_pc_r + 32'd4;
            end else begin
              state_r    <= IDLE;
              imem_req_r <= 1'b0;
            end
          end
        end
        DROP: begin
          if (ack_s) begin
            if (room_s) begin
              state_r     <= FETCH;
              imem_req_r  <= 1'b1;
              imem_addr_r <= fetch_pc_r;
            end else begin
              state_r    <= IDLE;
              imem_req_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          imem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (bus.redirect) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
    end
  end

  // Entry storage; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]   <= imem_addr_r;
      inst_mem_r[wr_ptr_r] <= bus.imem_rdata;
    end
  end

  // Head entry presented to decode, forced to zero while empty.
  always_comb begin
    bus.inst_valid = valid_s;
    if (valid_s) begin
      bus.inst_out = inst_mem_r[rd_ptr_r];
      bus.inst_pc  = pc_mem_r[rd_ptr_r];
    end else begin
      bus.inst_out = 32'h0000_0000;
      bus.inst_pc  = 32'h0000_0000;
    end
  end

  assign bus.imem_req  = imem_req_r;
  assign bus.imem_addr = imem_addr_r;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized
// traffic, all checked against a transaction-level model of the fetch stage.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  fetch_queue_if bus();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the outstanding request (if any), whether it was squashed,
  // the next fetch address and the list of buffered instructions.
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_fpc;
  logic        m_squash;
  ent_t        mq[$];

  task automatic model_reset();
    m_req = 1'b0; m_addr = RESET_PC; m_fpc = RESET_PC; m_squash = 1'b0;
    mq.delete();
  endtask

  task automatic model_step();
    logic ack, pop;
    ent_t e;
    ack = m_req && bus.imem_ack;
    pop = (mq.size() != 0) && bus.inst_ready;
    if (bus.redirect) begin
      mq.delete();
      m_fpc = {bus.redirect_pc[31:2], 2'b00};
      if (m_req && !ack) begin
        m_squash = 1'b1;
      end else begin
        m_req = 1'b1; m_addr = m_fpc; m_squash = 1'b0;
      end
    end else begin
      if (pop) void'(mq.pop_front());
      if (ack && !m_squash) begin
        e.pc = m_addr; e.inst = bus.imem_rdata;
        mq.push_back(e);
        m_fpc = m_addr + 32'd4;
      end
      if (ack || !m_req) begin
        m_squash = 1'b0;
        if (mq.size() < DEPTH) begin
          m_req = 1'b1; m_addr = m_fpc;
        end else begin
          m_req = 1'b0;
        end
      end
    end
  endtask

  function automatic logic [97:0] dut_snap();
    return {bus.imem_req, bus.imem_addr & {32{bus.imem_req}}, bus.inst_valid,
            bus.inst_out, bus.inst_pc};
  endfunction

  function automatic logic [97:0] exp_snap();
    ent_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    return {m_req, m_addr & {32{m_req}}, (mq.size() != 0), h.inst, h.pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask

  task automatic drive_idle();
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0; bus.inst_ready = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    #2;
    reset = 1'b0;
    model_reset();
    #2;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_addr: got %h want %h", bus.imem_addr, RESET_PC); end
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid); end
    n_cmp++; if (bus.inst_out !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", bus.inst_out); end
    n_cmp++; if (bus.inst_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", bus.inst_pc); end
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
      n_bad++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    bus.imem_ack = 1'b1; bus.inst_ready = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      bus.imem_rdata = 32'h0000_0013 + (bus.imem_addr >> 2);
      tick();
      n_cmp++; if (dut_snap() !== exp_snap()) begin n_bad++; $display("FAIL stream_model k=%0d: got %h want %h", k, dut_snap(), exp_snap()); end
      n_cmp++; if (bus.imem_addr !== 32'(4 * (k - 1))) begin n_bad++; $display("FAIL stream_addr k=%0d: got %h want %h", k, bus.imem_addr, 32'(4 * (k - 1))); end
      if (k >= 2) begin
        n_cmp++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * (k - 2)) || bus.inst_out !== 32'(32'h13 + k - 2)) begin
          n_bad++; $display("FAIL stream_head k=%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                            k, bus.inst_valid, bus.inst_pc, bus.inst_out, 32'(4 * (k - 2)), 32'(32'h13 + k - 2));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.imem_ack = 1'b1; bus.inst_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.imem_rdata = $urandom;
      tick();
      n_cmp++; if (dut_snap() !== exp_snap()) begin n_bad++; $display("FAIL bp_model k=%0d: got %h want %h", k, dut_snap(), exp_snap()); end
    end
    n_cmp++; if (bus.imem_req !== 1'b0 || bus.inst_pc !== 32'h0 || bus.inst_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_full: got req=%b v=%b pc=%h want req=0 v=1 pc=0", bus.imem_req, bus.inst_valid, bus.inst_pc);
    end
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10 || bus.inst_pc !== 32'h4) begin
      n_bad++; $display("FAIL bp_pop: got req=%b addr=%h pc=%h want req=1 addr=10 pc=4", bus.imem_req, bus.imem_addr, bus.inst_pc);
    end
    n_cmp++; if (dut_snap() !== exp_snap()) begin n_bad++; $display("FAIL bp_pop_model: got %h want %h", dut_snap(), exp_snap()); end
  endtask

  task automatic test_squash();
    do_reset();
    bus.inst_ready = 1'b1;
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
    tick();
    bus.redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0) begin
        n_bad++; $display("FAIL squash_hold k=%0d: got req=%b addr=%h v=%b want req=1 addr=0 v=0", k, bus.imem_req, bus.imem_addr, bus.inst_valid);
      end
      if (k < 2) tick();
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack = 1'b0;
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.inst_valid !== 1'b0) begin
      n_bad++; $display("FAIL squash_drop: got req=%b addr=%h v=%b want req=1 addr=100 v=0", bus.imem_req, bus.imem_addr, bus.inst_valid);
    end
    repeat (3) tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0010_0093;
    bus.inst_ready = 1'b0;
    tick();
    bus.imem_ack = 1'b0;
    n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100 || bus.inst_out !== 32'h0010_0093) begin
      n_bad++; $display("FAIL squash_first: got v=%b pc=%h inst=%h want v=1 pc=100 inst=00100093", bus.inst_valid, bus.inst_pc, bus.inst_out);
    end
    n_cmp++; if (dut_snap() !== exp_snap()) begin n_bad++; $display("FAIL squash_model: got %h want %h", dut_snap(), exp_snap()); end
  endtask

  task automatic test_redirect_collision();
    do_reset();
    bus.imem_ack = 1'b1;
    repeat (3) begin bus.imem_rdata = $urandom; tick(); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_2002; bus.inst_ready = 1'b1;
    tick();
    bus.redirect = 1'b0; bus.inst_ready = 1'b0;
    n_cmp++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h2000) begin
      n_bad++; $display("FAIL coll_flush: got v=%b req=%b addr=%h want v=0 req=1 addr=2000", bus.inst_valid, bus.imem_req, bus.imem_addr);
    end
    bus.imem_rdata = 32'h0000_ABCD;
    tick();
    n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h2000 || bus.inst_out !== 32'h0000_ABCD) begin
      n_bad++; $display("FAIL coll_target: got v=%b pc=%h inst=%h want v=1 pc=2000 inst=0000abcd", bus.inst_valid, bus.inst_pc, bus.inst_out);
    end
    n_cmp++; if (dut_snap() !== exp_snap()) begin n_bad++; $display("FAIL coll_model: got %h want %h", dut_snap(), exp_snap()); end
  endtask

  task automatic test_wrap();
    int pops;
    logic [31:0] exp_pc;
    do_reset();
    bus.imem_ack = 1'b1; bus.inst_ready = 1'b0;
    repeat (4) begin bus.imem_rdata = 32'h13 + (bus.imem_addr >> 2); tick(); end
    // three entries queued, request for 0xC acked together with a pop
    bus.imem_rdata = 32'h13 + (bus.imem_addr >> 2);
    bus.inst_ready = 1'b1;
    tick();
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10 || bus.inst_pc !== 32'h4) begin
      n_bad++; $display("FAIL wrap_pushpop: got req=%b addr=%h pc=%h want req=1 addr=10 pc=4", bus.imem_req, bus.imem_addr, bus.inst_pc);
    end
    pops = 1; exp_pc = 32'h4;
    for (int k = 0; k < 300 && pops < 3 * DEPTH; k++) begin
      bus.imem_rdata = 32'h13 + (bus.imem_addr >> 2);
      bus.inst_ready = ($urandom_range(0, 99) < 45);
      if (bus.inst_valid && bus.inst_ready) begin
        n_cmp++;
        if (bus.inst_pc !== exp_pc || bus.inst_out !== 32'h13 + (exp_pc >> 2)) begin
          n_bad++; $display("FAIL wrap_order pop=%0d: got pc=%h inst=%h want pc=%h inst=%h", pops, bus.inst_pc, bus.inst_out, exp_pc, 32'h13 + (exp_pc >> 2));
        end
        exp_pc += 32'd4; pops++;
      end
      tick();
      n_cmp++; if (dut_snap() !== exp_snap()) begin n_bad++; $display("FAIL wrap_model k=%0d: got %h want %h", k, dut_snap(), exp_snap()); end
    end
    n_cmp++; if (pops < 3 * DEPTH) begin n_bad++; $display("FAIL wrap_timeout: got %0d pops want %0d", pops, 3 * DEPTH); end
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      bus.imem_ack    = ($urandom_range(0, 99) < 70);
      bus.imem_rdata  = $urandom;
      bus.inst_ready  = ($urandom_range(0, 99) < 60);
      bus.redirect    = ($urandom_range(0, 99) < 4);
      bus.redirect_pc = $urandom;
      tick();
      n_cmp++; if (dut_snap() !== exp_snap()) begin n_bad++; $display("FAIL random_model k=%0d: got %h want %h", k, dut_snap(), exp_snap()); end
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.imem_ack = 1'b1;
    repeat (3) begin bus.imem_rdata = $urandom; tick(); end
    bus.imem_ack = 1'b0;
    n_cmp++; if (bus.inst_valid !== 1'b1 || bus.imem_addr !== 32'h8) begin
      n_bad++; $display("FAIL mid_setup: got v=%b addr=%h want v=1 addr=8", bus.inst_valid, bus.imem_addr);
    end
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== RESET_PC || bus.inst_valid !== 1'b0 ||
        bus.inst_out !== 32'h0 || bus.inst_pc !== 32'h0) begin
      n_bad++; $display("FAIL mid_reset: got req=%b addr=%h v=%b inst=%h pc=%h want all reset values",
                        bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst_out, bus.inst_pc);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
      n_bad++; $display("FAIL mid_restart: got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    test_reset();
    test_stream();
    test_backpressure();
    test_squash();
    test_redirect_collision();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
